// File: rtl/perf_mmio_responder_pkg.sv
// Shared LC-3b types for the performance-counter MMIO responder.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  localparam lc3b_word PERF_BASE    = 16'hFF00;
  localparam int       PERF_MAX_CTR = 16;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_FREEZE_BIT = 1;
  localparam int CTRL_CLEAR_BIT  = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    DONE = 2'd2
  } perf_state_t;

  // Software-visible CTRL word; the clear bit is a command and always reads 0.
  function automatic lc3b_word perf_ctrl_word(input logic en, input logic freeze);
    return {14'h0000, freeze, en};
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// 16-bit event counter that saturates at all-ones and flags the lost increment.
module perf_sat_counter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     clear,
  input  logic     hold,
  input  logic     inc,
  output lc3b_word count,
  output logic     ovf
);

  lc3b_word count_r;
  logic     ovf_r;

  // Count register with clear over increment; overflow is sticky until cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 16'h0000;
      ovf_r   <= 1'b0;
    end else if (clear) begin
      count_r <= 16'h0000;
      ovf_r   <= 1'b0;
    end else if (inc && !hold) begin
      if (count_r == 16'hFFFF) begin
        ovf_r <= 1'b1;
      end else begin
        count_r <= count_r + 16'h0001;
      end
    end
  end

  assign count = count_r;
  assign ovf   = ovf_r;

endmodule

// File: rtl/perf_mmio_responder.sv
// MMIO responder exposing a bank of saturating event counters plus CTRL/OVF
// registers over the LC-3b data-memory handshake.
module perf_mmio_responder
  import lc3b_types::*;
#(
  parameter int       NUM_CTR   = 8,
  parameter lc3b_word BASE_ADDR = PERF_BASE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_CTR-1:0] event_in,
  input  lc3b_word           mem_address,
  input  logic               mem_read,
  input  logic               mem_write,
  input  lc3b_word           mem_wdata,
  input  logic [1:0]         mem_byte_enable,
  output logic               mem_resp,
  output lc3b_word           mem_rdata,
  output logic               sel
);

  localparam logic [16:0] WIN_LEN  = 17'(2 * NUM_CTR + 4);
  localparam logic [4:0]  CTRL_IDX = 5'(NUM_CTR);
  localparam logic [4:0]  OVF_IDX  = 5'(NUM_CTR + 1);

  perf_state_t state_r, state_next_s;

  logic [16:0] offset_s;
  logic        in_win_s;
  logic        req_s;
  logic [4:0]  word_idx_s;
  lc3b_word    rd_val_s;

  lc3b_word          ctr_s [PERF_MAX_CTR];
  logic [15:0]       ovf_s;
  logic              en_r, freeze_r;
  logic              hold_s, clear_s, ctrl_commit_s;

  logic              we_r;
  logic [4:0]        idx_r;
  logic              wd_en_r, wd_frz_r, wd_clr_r;
  logic [1:0]        be_r;

  logic              latch_s, commit_s, resp_next_s;
  lc3b_word          rdata_next_s;
  logic              resp_r;
  lc3b_word          rdata_r;

  // 17-bit difference so addresses below the base show up as a borrow.
  assign offset_s   = {1'b0, mem_address} - {1'b0, BASE_ADDR};
  assign in_win_s   = !offset_s[16] && (offset_s < WIN_LEN);
  assign word_idx_s = offset_s[5:1];
  assign req_s      = (mem_read || mem_write) && in_win_s;
  assign sel        = req_s;

  assign hold_s        = !en_r || freeze_r;
  assign ctrl_commit_s = commit_s && (idx_r == CTRL_IDX);
  assign clear_s       = ctrl_commit_s && be_r[1] && wd_clr_r;

  // Unused slots are tied off so the read mux can index a fixed 16-entry bank.
  for (genvar i = 0; i < PERF_MAX_CTR; i++) begin : g_ctr
    if (i < NUM_CTR) begin : g_live
      perf_sat_counter u_ctr (
        .clk   (clk),
        .reset (reset),
        .clear (clear_s),
        .hold  (hold_s),
        .inc   (event_in[i]),
        .count (ctr_s[i]),
        .ovf   (ovf_s[i])
      );
    end else begin : g_tie
      assign ctr_s[i] = 16'h0000;
      assign ovf_s[i] = 1'b0;
    end
  end

  // Read mux over counters, CTRL and OVF.
  always_comb begin
    rd_val_s = 16'h0000;
    if (word_idx_s < CTRL_IDX) begin
      rd_val_s = ctr_s[word_idx_s[3:0]];
    end else if (word_idx_s == CTRL_IDX) begin
      rd_val_s = perf_ctrl_word(en_r, freeze_r);
    end else if (word_idx_s == OVF_IDX) begin
      rd_val_s = ovf_s;
    end else begin
      rd_val_s = 16'h0000;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = req_s ? RESP : IDLE;
      RESP:    state_next_s = DONE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: accept in IDLE, commit the latched write at the end of RESP.
  always_comb begin
    latch_s      = 1'b0;
    resp_next_s  = 1'b0;
    rdata_next_s = 16'h0000;
    commit_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          latch_s      = 1'b1;
          resp_next_s  = 1'b1;
          rdata_next_s = mem_write ? 16'h0000 : rd_val_s;
        end else begin
          latch_s     = 1'b0;
          resp_next_s = 1'b0;
        end
      end
      RESP:    commit_s = we_r;
      DONE:    commit_s = 1'b0;
      default: commit_s = 1'b0;
    endcase
  end

  // Request capture; only the CTRL bits that matter are kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_r     <= 1'b0;
      idx_r    <= 5'd0;
      wd_en_r  <= 1'b0;
      wd_frz_r <= 1'b0;
      wd_clr_r <= 1'b0;
      be_r     <= 2'b00;
    end else if (latch_s) begin
      we_r     <= mem_write;
      idx_r    <= word_idx_s;
      wd_en_r  <= mem_wdata[CTRL_EN_BIT];
      wd_frz_r <= mem_wdata[CTRL_FREEZE_BIT];
      wd_clr_r <= mem_wdata[CTRL_CLEAR_BIT];
      be_r     <= mem_byte_enable;
    end
  end

  // CTRL enable/freeze bits, gated by the low byte lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_r     <= 1'b1;
      freeze_r <= 1'b0;
    end else if (ctrl_commit_s && be_r[0]) begin
      en_r     <= wd_en_r;
      freeze_r <= wd_frz_r;
    end
  end

  // Response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_r  <= 1'b0;
      rdata_r <= 16'h0000;
    end else begin
      resp_r  <= resp_next_s;
      rdata_r <= rdata_next_s;
    end
  end

  // Reset raised during RESP must suppress the completion that is already registered.
  assign mem_resp  = resp_r && !reset;
  assign mem_rdata = reset ? 16'h0000 : rdata_r;

endmodule

// File: doc/perf_mmio_responder.md
# perf_mmio_responder

Memory-mapped responder that owns a bank of 16-bit event counters and serves them to software over the LC-3b data-memory handshake (`mem_read`/`mem_write`/`mem_resp`). It sits beside the data-cache port in the MP3 datapath. Pipeline event strobes (stalls, cache hits/misses, mispredicts) feed it, and LDR/STR to its address window read, freeze or clear the counters. It is the software-facing read end of the event-counting path.

## Interface
- `NUM_CTR`, 8: number of counters, 1..16.
- `BASE_ADDR`, 16'hFF00: word-aligned base of the window. Window length is `2*NUM_CTR+4` bytes.

- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `event_in`  in  NUM_CTR  level event strobes. Bit i set means counter i sees one event this cycle.
- `mem_address`  in  16  byte address (`lc3b_word`).
- `mem_read`  in  1  read request.
- `mem_write`  in  1  write request.
- `mem_wdata`  in  16  write data.
- `mem_byte_enable`  in  2  byte lanes, [0]=low.
- `mem_resp`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  16  read data. Valid while `mem_resp`=1, 0 otherwise.
- `sel`  out  1  combinational: address is in window and a request is active. The top level uses it to steer away from the cache.

## Operation
- Register map, byte offsets from BASE_ADDR, with `addr[0]` ignored:
  - Offsets 2i: CTR[i], read-only. Writes complete but have no effect.
  - Offset 2N: CTRL. Bit0 `en`, bit1 `freeze`, other bits read 0. Writing bit15=1 clears all counters and OVF; bit15 is not stored.
  - Offset 2N+2: OVF. Bit i is counter i's sticky saturation flag. Read-only.
- Counting: each cycle, if `en`=1, `freeze`=0 and `event_in[i]`=1, then CTR[i]+1.
  - Saturates at 16'hFFFF and does not wrap.
  - An increment attempted at 16'hFFFF sets OVF[i].
- Priority in one cycle, highest first: reset, then clear-write commit, then increment. A clear commit and an event in the same cycle leave CTR=0.
- CTRL writes honour `mem_byte_enable[0]` for bits 1:0 and `[1]` for bit15. With lane 1 off, no clear happens.
- `freeze`=1 holds all counters. Software reads a coherent set, then clears `freeze`.
- Requests outside the window: no state change, `mem_resp` stays 0, `sel`=0.
- `mem_read` and `mem_write` both high: treated as a write.
- FSM, 3 states:
  - IDLE: if a request is active and in window, latch address/op/data and go to RESP.
  - RESP: `mem_resp`=1, `mem_rdata` is the value latched at entry, write commits on this edge. Go to DONE.
  - DONE: ignore requests for one cycle, then go to IDLE. This gives the requester time to drop its request and prevents double service.
- Reset value of every output: `mem_resp`=0, `mem_rdata`=0. Resulting state: all CTR=0, OVF=0, CTRL.en=1, CTRL.freeze=0, FSM=IDLE.
- Reset mid-transaction returns to IDLE with no `mem_resp`. A pending write is dropped.

## Timing
- Request high at edge k (in IDLE) means `mem_resp`=1 during cycle k+1 and the write takes effect at edge k+1. Read latency is 1 cycle.
- Read data is the CTR value at edge k. Events at edge k are not included.
- Back-to-back requests: next service at the earliest 3 cycles after the prior one (IDLE→RESP→DONE→IDLE).
- `sel` is combinational from `mem_address`/`mem_read`/`mem_write`. It has no registered latency.
- Events keep counting during RESP and DONE.

## Structure
- In `lc3b_types`: `PERF_BASE` constant, `perf_state_t` enum (IDLE, RESP, DONE), and CTRL bit-index constants.
- One sub-module, `perf_sat_counter`: 16-bit saturating counter with clear, hold and inc inputs and a sticky overflow output. It is instantiated NUM_CTR times via generate.
- The top level holds the FSM, address decode and read mux.

## Test plan
- Reset, then `event_in[2]` high for 5 cycles, then read at FF04 → `mem_resp` at cycle k+1, `mem_rdata`=5. Other counters read 0.
- Preload CTR[0] to FFFE via events, then 3 more events → CTR[0]=FFFF and OVF (FF12 for N=8) = 16'h0001.
- Write CTRL (FF10) = 16'h0003 → counting frozen. Events for 10 cycles leave all CTR unchanged. Then write 16'h0001 and counting resumes.
- Write CTRL=16'h8001 with byte_enable=2'b11 while `event_in[1]`=1 → CTR[1]=0 and OVF=0 after the commit edge. With byte_enable=2'b01 → no clear.
- Hold `mem_read` at FF00 continuously for 6 cycles → `mem_resp` pulses at cycles 1 and 4 only. Read at 16'h1000 → `sel`=0 and no `mem_resp`.
- Assert `reset` in the RESP cycle of a CTRL write → no `mem_resp`. CTRL resets to 16'h0001 and FSM=IDLE next cycle.
